// File: rtl/iq_sweep_controller.sv
// iq_sweep_controller
// Steps the mixing NCO phase increment across a frequency sweep. After each
// frequency change it waits a programmable number of cycles for the FIR to
// settle, then averages 2^AVG_LOG2 valid I/Q samples and offers the result
// downstream over a valid/ready handshake.
module iq_sweep_controller #(
   parameter int W        = 14,
   parameter int AVG_LOG2 = 4,
   parameter int IDX_W    = 10
) (
   input  logic                    CLK,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic                    abort,
   input  logic [31:0]             start_inc,
   input  logic [31:0]             step_inc,
   input  logic [IDX_W-1:0]        num_points,
   input  logic [15:0]             settle_cycles,
   input  logic signed [W-1:0]     i_in,
   input  logic signed [W-1:0]     q_in,
   input  logic                    iq_valid,
   output logic [31:0]             phase_inc,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic signed [W-1:0]     res_i,
   output logic signed [W-1:0]     res_q,
   output logic [IDX_W-1:0]        res_index,
   output logic                    busy,
   output logic                    done
);

   localparam int ACC_W = W + AVG_LOG2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SETTLE,
      S_ACCUM,
      S_OUTPUT,
      S_FINISH
   } state_t;

   // Divide by the sample count with an arithmetic shift: floor toward -inf.
   function automatic logic signed [W-1:0] avg_floor(input logic signed [ACC_W-1:0] acc);
      logic signed [ACC_W-1:0] shifted;
      shifted = acc >>> AVG_LOG2;
      return W'(shifted);
   endfunction

   state_t                    r_state;
   state_t                    w_next_state;

   logic [31:0]               r_start_inc;
   logic [31:0]               r_step_inc;
   logic [IDX_W-1:0]          r_num_points;
   logic [15:0]               r_settle_cycles;

   logic [31:0]               r_phase_inc;
   logic [IDX_W-1:0]          r_idx;
   logic [15:0]               r_settle_cnt;
   logic signed [ACC_W-1:0]   r_acc_i;
   logic signed [ACC_W-1:0]   r_acc_q;
   logic [AVG_LOG2-1:0]       r_cnt;

   logic                      r_res_valid;
   logic signed [W-1:0]       r_res_i;
   logic signed [W-1:0]       r_res_q;
   logic [IDX_W-1:0]          r_res_index;

   logic                      w_last_sample;
   logic                      w_last_point;
   logic                      w_handshake;
   logic                      w_abort;
   logic signed [ACC_W-1:0]   w_acc_i_nxt;
   logic signed [ACC_W-1:0]   w_acc_q_nxt;

   assign w_last_sample = iq_valid && (r_cnt == {AVG_LOG2{1'b1}});
   assign w_last_point  = (r_idx == r_num_points - IDX_W'(1));
   assign w_handshake   = r_res_valid && res_ready;
   assign w_abort       = abort && (r_state != S_IDLE);
   assign w_acc_i_nxt   = r_acc_i + ACC_W'(i_in);
   assign w_acc_q_nxt   = r_acc_q + ACC_W'(q_in);

   assign phase_inc = r_phase_inc;
   assign res_valid = r_res_valid;
   assign res_i     = r_res_i;
   assign res_q     = r_res_q;
   assign res_index = r_res_index;

   // State register.
   always_ff @(posedge CLK) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode plus status outputs; abort overrides every transition.
   always_comb begin
      w_next_state = r_state;
      busy         = (r_state != S_IDLE);
      done         = (r_state == S_FINISH);
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next_state = (num_points != '0) ? S_LOAD : S_FINISH;
            end
         end
         S_LOAD:   w_next_state = S_SETTLE;
         S_SETTLE: begin
            if (r_settle_cnt == '0) w_next_state = S_ACCUM;
         end
         S_ACCUM: begin
            if (w_last_sample) w_next_state = S_OUTPUT;
         end
         S_OUTPUT: begin
            if (w_handshake) w_next_state = w_last_point ? S_FINISH : S_SETTLE;
         end
         S_FINISH: w_next_state = S_IDLE;
         default:  w_next_state = S_IDLE;
      endcase
      if (w_abort) w_next_state = S_IDLE;
   end

   // Sweep datapath: configuration latch, NCO stepping, settle timer,
   // accumulation and the result holding register.
   always_ff @(posedge CLK) begin
      if (!reset_n) begin
         r_start_inc     <= '0;
         r_step_inc      <= '0;
         r_num_points    <= '0;
         r_settle_cycles <= '0;
         r_phase_inc     <= '0;
         r_idx           <= '0;
         r_settle_cnt    <= '0;
         r_acc_i         <= '0;
         r_acc_q         <= '0;
         r_cnt           <= '0;
         r_res_valid     <= 1'b0;
         r_res_i         <= '0;
         r_res_q         <= '0;
         r_res_index     <= '0;
      end else if (w_abort) begin
         // Abort wins over a same-cycle handshake: drop the result, keep phase.
         r_res_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_start_inc     <= start_inc;
                  r_step_inc      <= step_inc;
                  r_num_points    <= num_points;
                  r_settle_cycles <= settle_cycles;
               end
            end
            S_LOAD: begin
               r_phase_inc  <= r_start_inc;
               r_idx        <= '0;
               r_settle_cnt <= r_settle_cycles;
            end
            S_SETTLE: begin
               if (r_settle_cnt == '0) begin
                  r_acc_i <= '0;
                  r_acc_q <= '0;
                  r_cnt   <= '0;
               end else begin
                  r_settle_cnt <= r_settle_cnt - 16'd1;
               end
            end
            S_ACCUM: begin
               if (iq_valid) begin
                  r_acc_i <= w_acc_i_nxt;
                  r_acc_q <= w_acc_q_nxt;
                  r_cnt   <= r_cnt + AVG_LOG2'(1);
                  if (w_last_sample) begin
                     r_res_i     <= avg_floor(w_acc_i_nxt);
                     r_res_q     <= avg_floor(w_acc_q_nxt);
                     r_res_index <= r_idx;
                     r_res_valid <= 1'b1;
                  end
               end
            end
            S_OUTPUT: begin
               if (w_handshake) begin
                  r_res_valid <= 1'b0;
                  if (!w_last_point) begin
                     r_phase_inc  <= r_phase_inc + r_step_inc;
                     r_idx        <= r_idx + IDX_W'(1);
                     r_settle_cnt <= r_settle_cycles;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_iq_sweep_controller.sv
// Directed bench for iq_sweep_controller: reset, basic sweep timing,
// averaging/floor behaviour, backpressure, phase wrap, empty sweep and abort.
module tb_iq_sweep_controller;

   localparam int W        = 14;
   localparam int AVG_LOG2 = 4;
   localparam int IDX_W    = 10;

   logic                 clk = 1'b0;
   logic                 reset_n;
   logic                 start;
   logic                 abort;
   logic [31:0]          start_inc;
   logic [31:0]          step_inc;
   logic [IDX_W-1:0]     num_points;
   logic [15:0]          settle_cycles;
   logic signed [W-1:0]  i_in;
   logic signed [W-1:0]  q_in;
   logic                 iq_valid;
   logic [31:0]          phase_inc;
   logic                 res_valid;
   logic                 res_ready;
   logic signed [W-1:0]  res_i;
   logic signed [W-1:0]  res_q;
   logic [IDX_W-1:0]     res_index;
   logic                 busy;
   logic                 done;

   int n_vec = 0;
   int n_err = 0;
   int ivec[16];
   int qvec[16];

   always #5 clk = ~clk;

   iq_sweep_controller #(.W(W), .AVG_LOG2(AVG_LOG2), .IDX_W(IDX_W)) dut (
      .CLK(clk), .reset_n(reset_n), .start(start), .abort(abort),
      .start_inc(start_inc), .step_inc(step_inc), .num_points(num_points),
      .settle_cycles(settle_cycles), .i_in(i_in), .q_in(q_in), .iq_valid(iq_valid),
      .phase_inc(phase_inc), .res_valid(res_valid), .res_ready(res_ready),
      .res_i(res_i), .res_q(res_q), .res_index(res_index), .busy(busy), .done(done)
   );

   task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_res(output int n);
      n = 0;
      while (res_valid !== 1'b1 && n < 300) begin
         tick();
         n++;
      end
      chk("res_valid_seen", res_valid, 1);
   endtask

   // One-point sweep fed with ivec/qvec, settle 0; checks the averaged result.
   task automatic avg_point(input string tag, input int ei, input int eq);
      num_points = 1; settle_cycles = 0; res_ready = 0; iq_valid = 0;
      start = 1; tick(); start = 0;
      tick();   // LOAD
      tick();   // SETTLE -> ACCUM
      for (int k = 0; k < 16; k++) begin
         i_in = ivec[k]; q_in = qvec[k]; iq_valid = 1;
         tick();
      end
      iq_valid = 0;
      chk({tag, "_valid"}, res_valid, 1);
      chk({tag, "_i"}, res_i, ei);
      chk({tag, "_q"}, res_q, eq);
      res_ready = 1; tick();
      chk({tag, "_done"}, done, 1);
      chk({tag, "_vld_clr"}, res_valid, 0);
      res_ready = 0; tick();
      chk({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      int n;
      int dev;
      logic [31:0] exp_phase[3];

      // Reset held with start asserted.
      reset_n = 0; start = 1; abort = 0; start_inc = 32'h1234; step_inc = 32'h10;
      num_points = 3; settle_cycles = 2; i_in = 5; q_in = 5; iq_valid = 1; res_ready = 1;
      tick(); tick(); tick();
      chk("rst_phase", phase_inc, 0);
      chk("rst_valid", res_valid, 0);
      chk("rst_i", res_i, 0);
      chk("rst_q", res_q, 0);
      chk("rst_index", res_index, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      start = 0; reset_n = 1;
      tick(); tick(); tick();
      chk("post_rst_busy", busy, 0);
      chk("post_rst_phase", phase_inc, 0);

      // Basic three-point sweep.
      exp_phase[0] = 32'd85899346; exp_phase[1] = 32'd94489281; exp_phase[2] = 32'd103079216;
      start_inc = 32'd85899346; step_inc = 32'd8589935; num_points = 3; settle_cycles = 5;
      i_in = 100; q_in = -100; iq_valid = 1; res_ready = 1;
      start = 1; tick(); start = 0;
      chk("basic_busy", busy, 1);
      tick();
      chk("basic_phase0", phase_inc, exp_phase[0]);
      for (int p = 0; p < 3; p++) begin
         wait_res(n);
         chk("basic_latency", n, 22);
         chk("basic_res_i", res_i, 100);
         chk("basic_res_q", res_q, -100);
         chk("basic_index", res_index, p);
         tick();
         chk("basic_vld_clr", res_valid, 0);
         if (p < 2) chk("basic_phase_step", phase_inc, exp_phase[p+1]);
         else       chk("basic_done", done, 1);
      end
      tick();
      chk("basic_done_pulse", done, 0);
      chk("basic_idle", busy, 0);
      chk("basic_phase_hold", phase_inc, exp_phase[2]);

      // Averaging: alternating 3/4 and constant -3.
      for (int k = 0; k < 16; k++) begin
         ivec[k] = (k % 2 == 0) ? 3 : 4;
         qvec[k] = -3;
      end
      avg_point("avg_alt", 3, -3);

      // Floor toward -inf (sum -17) and full-scale negative.
      for (int k = 0; k < 16; k++) begin
         ivec[k] = (k == 15) ? -2 : -1;
         qvec[k] = -8192;
      end
      avg_point("avg_floor", -2, -8192);

      // Backpressure with phase wrap; config changes after start must be ignored.
      start_inc = 32'hFFFFFFF0; step_inc = 32'h20; num_points = 2; settle_cycles = 0;
      i_in = 10; q_in = 20; iq_valid = 1; res_ready = 0;
      start = 1; tick(); start = 0;
      start_inc = 32'h12345678; step_inc = 32'h0;
      tick();
      chk("bp_phase0", phase_inc, 32'hFFFFFFF0);
      wait_res(n);
      chk("bp_latency", n, 17);
      chk("bp_res_i", res_i, 10);
      chk("bp_res_q", res_q, 20);
      i_in = 50; q_in = 60;
      dev = 0;
      for (int k = 0; k < 20; k++) begin
         start = (k == 5);
         tick();
         if (res_valid !== 1'b1 || res_i !== 14'sd10 || res_q !== 14'sd20 ||
             res_index !== '0 || phase_inc !== 32'hFFFFFFF0) dev++;
      end
      start = 0;
      chk("bp_stable", dev, 0);
      res_ready = 1; tick();
      chk("bp_vld_clr", res_valid, 0);
      chk("bp_phase_wrap", phase_inc, 32'h00000010);
      wait_res(n);
      chk("bp_res2_i", res_i, 50);
      chk("bp_res2_q", res_q, 60);
      chk("bp_index2", res_index, 1);
      tick();
      chk("bp_done", done, 1);
      res_ready = 0; tick();
      chk("bp_idle", busy, 0);

      // Empty sweep.
      num_points = 0;
      start = 1; tick(); start = 0;
      chk("empty_done", done, 1);
      chk("empty_valid", res_valid, 0);
      tick();
      chk("empty_done_pulse", done, 0);
      chk("empty_idle", busy, 0);

      // Abort during ACCUM of point 1.
      start_inc = 32'h100; step_inc = 32'h10; num_points = 3; settle_cycles = 0;
      i_in = 7; q_in = 7; iq_valid = 1; res_ready = 1;
      start = 1; tick(); start = 0;
      tick();
      wait_res(n);
      chk("abort_a_index", res_index, 0);
      tick();
      chk("abort_a_phase1", phase_inc, 32'h110);
      tick(); tick(); tick(); tick();
      abort = 1; tick(); abort = 0;
      chk("abort_a_idle", busy, 0);
      chk("abort_a_done", done, 0);
      chk("abort_a_valid", res_valid, 0);
      tick();
      chk("abort_a_done2", done, 0);
      chk("abort_a_phase_hold", phase_inc, 32'h110);

      // Abort in OUTPUT together with res_ready.
      start_inc = 32'h200; num_points = 2; res_ready = 0;
      start = 1; tick(); start = 0;
      tick();
      wait_res(n);
      abort = 1; res_ready = 1; tick(); abort = 0; res_ready = 0;
      chk("abort_o_valid", res_valid, 0);
      chk("abort_o_idle", busy, 0);
      chk("abort_o_done", done, 0);
      chk("abort_o_phase", phase_inc, 32'h200);
      tick();
      chk("abort_o_still_idle", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/iq_sweep_controller.md
Name: iq_sweep_controller

Overview:
- Sequences the IQ demodulator through a frequency sweep: drives the mixing NCO phase increment, waits for the FIR output to settle after each step, then averages 2^AVG_LOG2 valid I/Q samples per point.
- Hands each averaged result to a downstream consumer over a valid/ready handshake.
- Sits between the physical controls or host logic and the IQ module; replaces the static phase increment with a stepped one.

Parameters:
- W, 14: I/Q sample width (signed).
- AVG_LOG2, 4: log2 of the number of valid samples averaged per point (16).
- IDX_W, 10: width of the point count and index.

Ports:
- CLK  input  1  system clock (50 MHz domain)
- reset_n  input  1  synchronous, active-low reset
- start  input  1  begin sweep (sampled in IDLE only)
- abort  input  1  cancel sweep, return to IDLE
- start_inc  input  32  first phase increment
- step_inc  input  32  increment added per point (modulo 2^32)
- num_points  input  IDX_W  number of sweep points
- settle_cycles  input  16  CLK cycles to wait after each frequency change
- i_in  input  W  signed I sample from IQ module
- q_in  input  W  signed Q sample from IQ module
- iq_valid  input  1  i_in/q_in valid this cycle
- phase_inc  output  32  phase increment to mixing NCO
- res_valid  output  1  averaged result available
- res_ready  input  1  consumer accepts result
- res_i  output  W  averaged I
- res_q  output  W  averaged Q
- res_index  output  IDX_W  point index of the result
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle pulse at sweep completion

Behaviour:
- Reset (reset_n=0 at a CLK edge): state IDLE; phase_inc=0; res_valid=0; res_i=res_q=0; res_index=0; busy=0; done=0; accumulators and counters cleared. Reset overrides all other inputs.
- States: IDLE, LOAD, SETTLE, ACCUM, OUTPUT, FINISH.
- IDLE:
  - start=1 and num_points≠0 -> LOAD.
  - start=1 and num_points=0 -> FINISH (done pulse, no results).
  - Inputs start_inc, step_inc, num_points and settle_cycles are latched on the start cycle. Later changes have no effect until the next sweep.
- LOAD (1 cycle): phase_inc<=start_inc; idx<=0; settle counter<=settle_cycles; -> SETTLE.
- SETTLE:
  - Counter decrements each cycle; iq_valid is ignored.
  - When the counter is 0 -> ACCUM. With settle_cycles=0, SETTLE lasts exactly 1 cycle.
- ACCUM:
  - On each iq_valid=1, add sign-extended i_in/q_in into (W+AVG_LOG2)-bit accumulators and increment the sample count.
  - After the 2^AVG_LOG2-th valid sample -> OUTPUT.
  - In the same edge: res_i/res_q <= accumulator >>> AVG_LOG2 (arithmetic shift, floor toward -inf), res_index<=idx, res_valid<=1.
  - Accumulators and count clear on entry to ACCUM.
- OUTPUT:
  - res_valid, res_i, res_q and res_index are held stable until res_valid&res_ready at a CLK edge. Further samples are ignored; no advance without the handshake.
  - On handshake: res_valid<=0.
  - If idx=num_points-1 -> FINISH.
  - Otherwise phase_inc<=phase_inc+step_inc (wraps mod 2^32), idx<=idx+1, settle counter reloaded -> SETTLE.
- FINISH (1 cycle): done=1; -> IDLE. phase_inc retains its last value.
- abort=1 in any non-IDLE state: next state IDLE; res_valid<=0; done not asserted; phase_inc retains its value. abort has priority over the handshake in the same cycle.
- start while busy is ignored.
- Latency:
  - start edge to phase_inc valid: 2 cycles.
  - Last valid sample to res_valid: 1 cycle.
  - Handshake to next phase_inc: 1 cycle.

Test Plan:
- Reset: hold reset_n=0 with start=1 -> all outputs 0, busy=0; release -> stays IDLE until the next start.
- Basic sweep: start_inc=85899346, step_inc=8589935, num_points=3, settle_cycles=5, i_in=100, q_in=-100, iq_valid=1, res_ready=1 -> phase_inc sequence 85899346, 94489281, 103079216; three results (100,-100) with idx 0,1,2; first res_valid 5+1+16 cycles after SETTLE entry; done pulses once.
- Averaging/rounding: i_in alternating 3,4 and q_in constant -3 over 16 valid samples -> res_i=3, res_q=-3. Sum=-17 over 16 samples -> -2 (floor).
- Backpressure: res_ready=0 for 20 cycles while samples keep arriving -> res outputs stable, phase_inc unchanged; res_ready=1 -> one transfer, then advance.
- Boundaries: num_points=0 -> done next cycle, no res_valid. start_inc=0xFFFFFFF0, step_inc=0x20 -> second phase_inc=0x00000010.
- Abort: abort=1 during ACCUM of point 1 with res_valid=0 -> IDLE next cycle, no done pulse. Abort in OUTPUT with res_ready=1 on the same cycle -> no transfer counted, res_valid=0.
